// File: rtl/shift_pkg.sv
// shift_pkg: shared encodings, widths and the barrel-shifter stage helper.
package shift_pkg;
    localparam int DATA_W = 32;
    localparam int SHAMT_W = 5;
    typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROR = 2'b11} op_t;
    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_BUSY = 2'b01, ST_DONE = 2'b10} state_t;
    // One barrel stage; SRL and SRA share the right path, differing only in fill.
    function automatic logic [DATA_W-1:0] shift_stage(op_t op, logic [DATA_W-1:0] x, int s, logic fill);
        logic [DATA_W-1:0] rs;
        rs = (x >> s) | ({DATA_W{fill}} & ~({DATA_W{1'b1}} >> s));
        return op == OP_SLL ? x << s : op == OP_ROR ? (x >> s) | (x << (DATA_W - s)) : rs;
    endfunction
endpackage

// File: rtl/shift_core.sv
// shift_core: combinational 16/8/4/2/1 barrel shifter for SLL/SRL/SRA/ROR.
module shift_core
    import shift_pkg::*;
(
    input  op_t               op,
    input  logic [DATA_W-1:0] a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0] y
);
    logic fill;
    assign fill = (op == OP_SRA) & a[DATA_W-1];
    always_comb begin
        y = a;
        for (int k = SHAMT_W - 1; k >= 0; k--)
            if (shamt[k]) y = shift_stage(op, y, 1 << k, fill);
    end
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter sharing one registered barrel shifter
// between NUM_REQ requesters, holding the tagged result until accepted.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W = 1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [2*NUM_REQ-1:0]        req_op,
    input  logic [DATA_W*NUM_REQ-1:0]   req_a,
    input  logic [SHAMT_W*NUM_REQ-1:0]  req_shamt,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [ID_W-1:0]             rsp_id
);
    localparam logic [ID_W:0] NR = (ID_W + 1)'(NUM_REQ);
    state_t state;
    logic [ID_W-1:0] ptr, off, gnt, id_q;
    logic [ID_W:0] sum, nxt;
    logic [2*NUM_REQ-1:0] vv;
    logic [NUM_REQ-1:0] rot;
    logic hit;
    op_t op_q;
    logic [DATA_W-1:0] a_q, core_y;
    logic [SHAMT_W-1:0] shamt_q;
    logic [1:0] op_v [NUM_REQ];
    logic [DATA_W-1:0] a_v [NUM_REQ];
    logic [SHAMT_W-1:0] sh_v [NUM_REQ];
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_v[i] = req_op[2*i +: 2];
        assign a_v[i] = req_a[DATA_W*i +: DATA_W];
        assign sh_v[i] = req_shamt[SHAMT_W*i +: SHAMT_W];
    end
    // Rotate valids so bit 0 is the requester at ptr; the lowest set bit wins.
    always_comb begin
        vv = {req_valid, req_valid};
        rot = NUM_REQ'(vv >> ptr);
        hit = |rot;
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (rot[k]) off = ID_W'(k);
        sum = {1'b0, ptr} + {1'b0, off};
        gnt = (sum >= NR) ? ID_W'(sum - NR) : sum[ID_W-1:0];
        nxt = {1'b0, gnt} + 1'b1;
        req_ready = (state == ST_IDLE && hit) ? NUM_REQ'(1) << gnt : '0;
    end
    shift_core u_core (
        .op    (op_q),
        .a     (a_q),
        .shamt (shamt_q),
        .y     (core_y)
    );
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            ptr <= '0;
            op_q <= OP_SLL;
            a_q <= '0;
            shamt_q <= '0;
            id_q <= '0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            rsp_id <= '0;
        end else if (state == ST_IDLE) begin
            if (hit) begin
                op_q <= op_t'(op_v[gnt]);
                a_q <= a_v[gnt];
                shamt_q <= sh_v[gnt];
                id_q <= gnt;
                ptr <= (nxt == NR) ? '0 : nxt[ID_W-1:0];
                state <= ST_BUSY;
            end
        end else if (state == ST_BUSY) begin
            rsp_data <= core_y;
            rsp_id <= id_q;
            rsp_valid <= 1'b1;
            state <= ST_DONE;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state <= ST_IDLE;
        end
    end
endmodule
